mem_bus_port: RTL

//  Memory port hanging off the CPU's shared OR-bus. Consumes the bus value (cpu_addr_in path) into an address register AM.

---
 rtl/mem_bus_port.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_port.sv
// ---------------------------------------------------------------------------
// mem_bus_port
//   Memory port on the CPU's shared wired-OR bus. The bus value is captured
//   into the address register AM (ld_addr) or, for writes, into the data
//   register MDR. A level req/ack handshake to RAM then runs with a bounded
//   wait; read data lands in MDR and is driven back onto the bus on request.
//   Because the bus is wired-OR, o_data_out is all-zero unless the port is
//   idle and explicitly driving.
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      asynchronous, active-high; clears all state
//   i_bus_in     bus value (address or write data)
//   i_ld_addr    load AM from the bus
//   i_rd_req     start read of mem[AM]
//   i_wr_req     start write mem[AM] <= bus value
//   i_drv_en     drive MDR onto the bus (ignored while busy)
//   o_data_out   MDR when driving and idle, else 0 (combinational)
//   o_busy       operation in progress
//   o_done       one-cycle pulse on successful completion
//   o_err        one-cycle pulse on illegal command or timeout
//   o_mem_addr   RAM address (= AM)
//   o_mem_wdata  RAM write data (= MDR)
//   o_mem_req    RAM request, held until ack or timeout
//   o_mem_we     1 = write, valid while o_mem_req
//   i_mem_rdata  RAM read data, valid with i_mem_ack
//   i_mem_ack    RAM completion, single cycle
// ---------------------------------------------------------------------------
module mem_bus_port #(
  parameter int WORD_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15   // 1..255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WORD_WIDTH-1:0] i_bus_in,
  input  logic                  i_ld_addr,
  input  logic                  i_rd_req,
  input  logic                  i_wr_req,
  input  logic                  i_drv_en,
  output logic [WORD_WIDTH-1:0] o_data_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [WORD_WIDTH-1:0] o_mem_addr,
  output logic [WORD_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  input  logic [WORD_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_am;
  logic [WORD_WIDTH-1:0] r_mdr;
  logic                  r_op_we;
  logic [7:0]            r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_mem_req;
  logic                  r_mem_we;

  // A write takes its data from the bus, so it cannot share the cycle with an
  // address load or with a read.
  logic w_illegal;
  assign w_illegal = i_wr_req & (i_rd_req | i_ld_addr);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_am      <= '0;
      r_mdr     <= '0;
      r_op_we   <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
    end else begin
      // Pulses default low; only the transitions below raise them for a cycle.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_illegal) begin
            r_err <= 1'b1;
          end else begin
            // Address load happens alongside rd_req so the read uses the new AM.
            if (i_ld_addr) r_am <= i_bus_in;
            if (i_wr_req) begin
              r_mdr     <= i_bus_in;
              r_op_we   <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_REQ;
              r_busy    <= 1'b1;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b1;
            end else if (i_rd_req) begin
              r_op_we   <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_REQ;
              r_busy    <= 1'b1;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end
        S_REQ: begin
          // Ack is tested first so an ack in the last allowed cycle still wins.
          if (i_mem_ack) begin
            if (!r_op_we) r_mdr <= i_mem_rdata;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else if (r_cnt == LP_LAST_CNT) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_out  = (i_drv_en && !r_busy) ? r_mdr : '0;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_mem_addr  = r_am;
  assign o_mem_wdata = r_mdr;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;

endmodule
